// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, widths and pc helpers for the fetch stage
package fetch_pkg;

    localparam int VIRTUAL_ADDRESS_SIZE = 64;
    localparam int NFU                  = 2;
    localparam int BUNDLE_BITS          = NFU * 32;
    localparam int BUNDLE_BYTES         = NFU * 4;

    typedef logic [VIRTUAL_ADDRESS_SIZE-1:0] vaddr_t;
    typedef logic [BUNDLE_BITS-1:0]          bundle_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        bundle_t bundle;
        vaddr_t  pc;
    } queue_entry_t;

    // Clear the byte-offset bits so every pc points at a bundle boundary.
    function automatic vaddr_t alignPc(input vaddr_t pc);
        return pc & ~vaddr_t'(BUNDLE_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - mmu instruction port, redirect and decode handshake bundle
interface fetch_unit_if;
    import fetch_pkg::*;

    vaddr_t  instructionAddress;
    logic    doInstructionFetch;
    bundle_t instruction;
    logic    doneInstructionFetch;
    logic    redirectValid;
    vaddr_t  redirectPc;
    logic    bundleValid;
    logic    bundleReady;
    bundle_t bundle;
    vaddr_t  bundlePc;

    modport master (
        output instructionAddress, doInstructionFetch,
        output bundleValid, bundle, bundlePc,
        input  instruction, doneInstructionFetch,
        input  redirectValid, redirectPc,
        input  bundleReady
    );

    modport slave (
        input  instructionAddress, doInstructionFetch,
        input  bundleValid, bundle, bundlePc,
        output instruction, doneInstructionFetch,
        output redirectValid, redirectPc,
        output bundleReady
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - bundle FIFO with registered head, flush and occupancy count
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int QUEUE_DEPTH = 4,
    localparam int PTR_BITS    = $clog2(QUEUE_DEPTH),
    localparam int COUNT_BITS  = PTR_BITS + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  queue_entry_t          pushEntry,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  headValid,
    output queue_entry_t          head,
    output logic [COUNT_BITS-1:0] count,
    output logic                  full,
    output logic                  empty
);

    queue_entry_t          mem [QUEUE_DEPTH];
    logic [PTR_BITS-1:0]   rdPtr;
    logic [PTR_BITS-1:0]   wrPtr;
    logic                  doPush;
    logic                  doPop;
    logic [PTR_BITS-1:0]   nextRd;
    logic [COUNT_BITS-1:0] nextCount;
    logic [COUNT_BITS-1:0] afterPop;

    assign full  = (count == COUNT_BITS'(QUEUE_DEPTH));
    assign empty = (count == '0);

    // Qualify push/pop against flush and occupancy, and work out the next head position.
    always_comb begin
        doPop     = 1'b0;
        doPush    = 1'b0;
        nextRd    = rdPtr;
        nextCount = count;
        afterPop  = count;
        doPop     = pop & headValid & ~flush;
        doPush    = push & ~flush & (~full | doPop);
        nextRd    = rdPtr + PTR_BITS'(doPop);
        afterPop  = count - COUNT_BITS'(doPop);
        nextCount = afterPop + COUNT_BITS'(doPush);
    end

    // Entry storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushEntry;
        end
    end

    // Pointers, count and the registered head; a push into an empty queue bypasses storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            headValid <= 1'b0;
            head      <= '0;
        end else if (flush) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            headValid <= 1'b0;
        end else begin
            rdPtr     <= nextRd;
            count     <= nextCount;
            headValid <= (nextCount != '0);
            if (doPush) begin
                wrPtr <= wrPtr + PTR_BITS'(1);
            end
            if (doPush && afterPop == '0) begin
                head <= pushEntry;
            end else if (nextCount != '0) begin
                head <= mem[nextRd];
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage top: pc, fetch FSM, redirect discard, bundle queue; FETCH_PERF_EN adds perf counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int     QUEUE_DEPTH = 4,
    parameter vaddr_t RESET_PC    = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.master fif
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perfBundleCount,
    output logic [31:0] perfStallCount
`endif
);

    localparam int COUNT_BITS = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_e          state;
    vaddr_t                pc;
    vaddr_t                fetchAddress;
    logic                  fetchPulse;
    logic                  discard;

    logic                  qPush;
    logic                  qPop;
    queue_entry_t          qPushEntry;
    queue_entry_t          qHead;
    logic                  qHeadValid;
    logic [COUNT_BITS-1:0] qCount;
    logic                  qFull;
    logic                  qEmpty;
    logic                  creditAvailable;

    assign fif.instructionAddress = fetchAddress;
    assign fif.doInstructionFetch = fetchPulse;
    assign fif.bundleValid        = qHeadValid;
    assign fif.bundle             = qHead.bundle;
    assign fif.bundlePc           = qHead.pc;

    // Only issued from IDLE, so nothing is in flight and the queue count alone is the credit.
    assign creditAvailable = (qCount < COUNT_BITS'(QUEUE_DEPTH));

    assign qPush = (state == WAIT) & fif.doneInstructionFetch & ~discard
                 & ~fif.redirectValid & ~qFull;
    assign qPop  = qHeadValid & fif.bundleReady & ~qEmpty;

    assign qPushEntry.bundle = fif.instruction;
    assign qPushEntry.pc     = fetchAddress;

    fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (qPush),
        .pushEntry (qPushEntry),
        .pop       (qPop),
        .flush     (fif.redirectValid),
        .headValid (qHeadValid),
        .head      (qHead),
        .count     (qCount),
        .full      (qFull),
        .empty     (qEmpty)
    );

    // Fetch FSM: registered request pulse, pc advance on kept responses, redirect with discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            fetchAddress <= RESET_PC;
            fetchPulse   <= 1'b0;
            discard      <= 1'b0;
        end else begin
            fetchPulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (fif.redirectValid) begin
                        pc <= alignPc(fif.redirectPc);
                    end else if (creditAvailable) begin
                        state        <= REQ;
                        fetchPulse   <= 1'b1;
                        fetchAddress <= pc;
                    end
                end
                REQ: begin
                    state <= WAIT;
                    if (fif.redirectValid) begin
                        pc      <= alignPc(fif.redirectPc);
                        discard <= 1'b1;
                    end
                end
                WAIT: begin
                    if (fif.doneInstructionFetch) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                        if (fif.redirectValid) begin
                            pc <= alignPc(fif.redirectPc);
                        end else if (!discard) begin
                            pc <= pc + vaddr_t'(BUNDLE_BYTES);
                        end
                    end else if (fif.redirectValid) begin
                        pc      <= alignPc(fif.redirectPc);
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counts of bundles pushed and cycles spent waiting on the mmu.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfBundleCount <= '0;
            perfStallCount  <= '0;
        end else begin
            if (qPush && perfBundleCount != 32'hFFFF_FFFF) begin
                perfBundleCount <= perfBundleCount + 32'd1;
            end
            if (state == WAIT && perfStallCount != 32'hFFFF_FFFF) begin
                perfStallCount <= perfStallCount + 32'd1;
            end
        end
    end
`endif

endmodule
